// File: rtl/unary_adder_acc_pkg.sv
// -----------------------------------------------------------------------------
// unary_adder_acc_pkg
// Shared constants for the unary adder/accumulator block.
//   WIDTH_DEF  : default accumulator width (values 0..2^WIDTH-1)
//   MODE_WRITE : read_or_write encoding for accumulate mode
//   MODE_READ  : read_or_write encoding for unary replay mode
// -----------------------------------------------------------------------------
package unary_adder_acc_pkg;

    localparam int WIDTH_DEF = 9;

    localparam logic MODE_WRITE = 1'b0;
    localparam logic MODE_READ  = 1'b1;

    // Decoded view of the mode pin, used by the top-level next-state logic.
    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2
    } acc_op_e;

    // Collapse enable and mode pins into a single operation code.
    function automatic acc_op_e decode_op(input logic en, input logic mode);
        acc_op_e op;
        if (!en) begin
            op = OP_HOLD;
        end else if (mode == MODE_READ) begin
            op = OP_READ;
        end else begin
            op = OP_WRITE;
        end
        return op;
    endfunction

endpackage

// File: rtl/unary_adder_acc_serializer.sv
// -----------------------------------------------------------------------------
// unary_serializer
// Read-mode half of the accumulator: computes the decremented count and
// generates the registered unary pulse on dout (one pulse per stored unit).
// The count register itself lives in the top so it stays visible as "count".
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : block enable; dout holds when low
//   rd_sel     : 1 when the block is in read mode
//   count      : current accumulator value
//   count_dec  : next accumulator value for a read cycle (saturates at 0)
//   dout       : registered unary output pulse
// -----------------------------------------------------------------------------
module unary_serializer
    import unary_adder_acc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             rd_sel,
    input  logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_dec,
    output logic             dout
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic nonzero_s;
    logic dout_next_s;
    logic dout_r;

    // Down-count with floor at zero so an empty counter never wraps.
    always_comb begin
        nonzero_s = (count != ZERO);
        count_dec = count;
        if (nonzero_s) begin
            count_dec = count - ONE;
        end else begin
            count_dec = ZERO;
        end
    end

    // A pulse is emitted only while reading a non-empty counter; write mode forces 0.
    always_comb begin
        dout_next_s = 1'b0;
        if (rd_sel && nonzero_s) begin
            dout_next_s = 1'b1;
        end else begin
            dout_next_s = 1'b0;
        end
    end

    // Output pulse register, held while the block is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_r <= 1'b0;
        end else if (en) begin
            dout_r <= dout_next_s;
        end else begin
            dout_r <= dout_r;
        end
    end

    assign dout = dout_r;

endmodule

// File: rtl/unary_adder_acc.sv
// -----------------------------------------------------------------------------
// unary_adder_acc
// Adds two unary pulse streams (A, B) into a binary accumulator in write mode
// and replays the total as a unary pulse train on dout in read mode.
// Ports:
//   clk           : rising-edge clock
//   rst_n         : asynchronous active-low reset (clears count, dout, C)
//   A, B          : unary operand streams, each high sample adds 1
//   en            : block enable; all state holds when low
//   read_or_write : 0 = accumulate, 1 = replay
//   dout          : registered unary output
//   C             : registered sticky overflow flag, cleared only by reset
// -----------------------------------------------------------------------------
module unary_adder_acc
    import unary_adder_acc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic A,
    input  logic B,
    input  logic en,
    input  logic read_or_write,
    output logic dout,
    output logic C
);

    // Accumulator; name kept as "count" for hierarchical debug access.
    logic [WIDTH-1:0] count;
    logic             c_r;

    acc_op_e          op_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] count_dec_s;
    logic [WIDTH-1:0] count_next_s;
    logic             carry_set_s;
    logic             rd_sel_s;

    assign rd_sel_s = (read_or_write == MODE_READ);

    unary_serializer #(
        .WIDTH (WIDTH)
    ) u_serializer (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rd_sel    (rd_sel_s),
        .count     (count),
        .count_dec (count_dec_s),
        .dout      (dout)
    );

    // Sum is one bit wider than the counter so the top bit flags overflow.
    always_comb begin
        sum_s = {1'b0, count} + {{WIDTH{1'b0}}, A} + {{WIDTH{1'b0}}, B};
    end

    // Select next accumulator value and whether this edge sets the carry.
    always_comb begin
        op_s         = decode_op(en, read_or_write);
        count_next_s = count;
        carry_set_s  = 1'b0;
        case (op_s)
            OP_WRITE: begin
                count_next_s = sum_s[WIDTH-1:0];
                carry_set_s  = sum_s[WIDTH];
            end
            OP_READ: begin
                count_next_s = count_dec_s;
                carry_set_s  = 1'b0;
            end
            OP_HOLD: begin
                count_next_s = count;
                carry_set_s  = 1'b0;
            end
            default: begin
                count_next_s = count;
                carry_set_s  = 1'b0;
            end
        endcase
    end

    // Accumulator register; next value already accounts for enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= {WIDTH{1'b0}};
        end else begin
            count <= count_next_s;
        end
    end

    // Sticky overflow flag: once set it stays until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_r <= 1'b0;
        end else if (carry_set_s) begin
            c_r <= 1'b1;
        end else begin
            c_r <= c_r;
        end
    end

    assign C = c_r;

endmodule

// File: tb/tb_unary_adder_acc.sv
module tb_unary_adder_acc;

    logic clk;
    logic rst_n;
    logic A;
    logic B;
    logic en;
    logic read_or_write;
    logic dout;
    logic C;

    int errors;
    int checks;

    unary_adder_acc #(.WIDTH(9)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .A             (A),
        .B             (B),
        .en            (en),
        .read_or_write (read_or_write),
        .dout          (dout),
        .C             (C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        A = 1'b0; B = 1'b0; en = 1'b0; read_or_write = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        A = 1'b0; B = 1'b0; en = 1'b0; read_or_write = 1'b0;
        tick();
        checks++;
        if (dut.count !== 9'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", dut.count); end
        checks++;
        if (dout !== 1'b0) begin errors++; $display("FAIL reset_dout: got %b want 0", dout); end
        checks++;
        if (C !== 1'b0) begin errors++; $display("FAIL reset_C: got %b want 0", C); end
        rst_n = 1'b1;
    endtask

    task automatic test_accumulate();
        logic [8:0] exp_cnt [5];
        exp_cnt[0] = 9'd1; exp_cnt[1] = 9'd2; exp_cnt[2] = 9'd3;
        exp_cnt[3] = 9'd5; exp_cnt[4] = 9'd7;
        apply_reset();
        en = 1'b1; read_or_write = 1'b0;
        for (int i = 0; i < 5; i++) begin
            A = 1'b1;
            B = (i >= 3) ? 1'b1 : 1'b0;
            tick();
            checks++;
            if (dut.count !== exp_cnt[i]) begin errors++; $display("FAIL acc_count[%0d]: got %0d want %0d", i, dut.count, exp_cnt[i]); end
            checks++;
            if (dout !== 1'b0) begin errors++; $display("FAIL acc_dout[%0d]: got %b want 0", i, dout); end
        end
        checks++;
        if (C !== 1'b0) begin errors++; $display("FAIL acc_C: got %b want 0", C); end
        A = 1'b0; B = 1'b0;
    endtask

    task automatic test_enable_gating();
        apply_reset();
        en = 1'b1; read_or_write = 1'b0;
        A = 1'b1; B = 1'b1; tick(); tick();
        A = 1'b1; B = 1'b0; tick();
        checks++;
        if (dut.count !== 9'd5) begin errors++; $display("FAIL gate_setup: got %0d want 5", dut.count); end
        en = 1'b0; A = 1'b1; B = 1'b1;
        for (int m = 0; m < 2; m++) begin
            read_or_write = (m == 1) ? 1'b1 : 1'b0;
            for (int i = 0; i < 4; i++) begin
                tick();
                checks++;
                if (dut.count !== 9'd5) begin errors++; $display("FAIL gate_count[m%0d,%0d]: got %0d want 5", m, i, dut.count); end
                checks++;
                if (dout !== 1'b0) begin errors++; $display("FAIL gate_dout[m%0d,%0d]: got %b want 0", m, i, dout); end
            end
        end
        // One enabled read raises dout, then disabling must freeze it high.
        en = 1'b1; read_or_write = 1'b1; tick();
        checks++;
        if (dut.count !== 9'd4 || dout !== 1'b1) begin errors++; $display("FAIL gate_read1: got count=%0d dout=%b want 4/1", dut.count, dout); end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dut.count !== 9'd4 || dout !== 1'b1) begin errors++; $display("FAIL gate_hold_hi[%0d]: got count=%0d dout=%b want 4/1", i, dut.count, dout); end
        end
        A = 1'b0; B = 1'b0;
    endtask

    task automatic test_empty_read();
        apply_reset();
        en = 1'b1; read_or_write = 1'b1; A = 1'b1; B = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (dout !== 1'b0 || dut.count !== 9'd0) begin errors++; $display("FAIL empty_read[%0d]: got dout=%b count=%0d want 0/0", i, dout, dut.count); end
        end
        A = 1'b0; B = 1'b0;
    endtask

    task automatic test_boundaries();
        // 511 + A -> 0 with carry
        apply_reset();
        en = 1'b1; read_or_write = 1'b0;
        A = 1'b1; B = 1'b1;
        for (int i = 0; i < 255; i++) tick();
        A = 1'b1; B = 1'b0; tick();
        checks++;
        if (dut.count !== 9'd511 || C !== 1'b0) begin errors++; $display("FAIL bnd_511: got count=%0d C=%b want 511/0", dut.count, C); end
        tick();
        checks++;
        if (dut.count !== 9'd0 || C !== 1'b1) begin errors++; $display("FAIL bnd_511_plus1: got count=%0d C=%b want 0/1", dut.count, C); end
        // 511 + A + B -> 1 with carry
        apply_reset();
        en = 1'b1; read_or_write = 1'b0;
        A = 1'b1; B = 1'b1;
        for (int i = 0; i < 255; i++) tick();
        A = 1'b1; B = 1'b0; tick();
        A = 1'b1; B = 1'b1; tick();
        checks++;
        if (dut.count !== 9'd1 || C !== 1'b1) begin errors++; $display("FAIL bnd_511_plus2: got count=%0d C=%b want 1/1", dut.count, C); end
        A = 1'b0; B = 1'b0;
    endtask

    task automatic test_overflow();
        apply_reset();
        en = 1'b1; read_or_write = 1'b0;
        for (int it = 1; it <= 257; it++) begin
            A = 1'b1; B = 1'b1; tick();
            if (it == 255) begin
                checks++;
                if (dut.count !== 9'd510 || C !== 1'b0) begin errors++; $display("FAIL ovf_it255: got count=%0d C=%b want 510/0", dut.count, C); end
            end
            if (it == 256) begin
                checks++;
                if (dut.count !== 9'd0 || C !== 1'b1) begin errors++; $display("FAIL ovf_it256: got count=%0d C=%b want 0/1", dut.count, C); end
            end
            A = 1'b0; B = 1'b0; tick();
        end
        checks++;
        if (dut.count !== 9'd2 || C !== 1'b1) begin errors++; $display("FAIL ovf_final: got count=%0d C=%b want 2/1", dut.count, C); end
    endtask

    // Runs straight after test_overflow: count=2, C=1.
    task automatic test_back_to_back_readout();
        int highs;
        highs = 0;
        en = 1'b1; read_or_write = 1'b1; A = 1'b1; B = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dout === 1'b1) highs++;
            checks++;
            if (dout !== ((i < 2) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL read_dout[%0d]: got %b want %b", i, dout, (i < 2) ? 1'b1 : 1'b0); end
        end
        checks++;
        if (highs != 2) begin errors++; $display("FAIL read_pulses: got %0d want 2", highs); end
        checks++;
        if (dut.count !== 9'd0) begin errors++; $display("FAIL read_count: got %0d want 0", dut.count); end
        checks++;
        if (C !== 1'b1) begin errors++; $display("FAIL read_C: got %b want 1", C); end
        A = 1'b0; B = 1'b0;
    endtask

    // Runs with C=1 still set: build count, raise dout, then reset mid-cycle.
    task automatic test_async_reset();
        en = 1'b1; read_or_write = 1'b0; A = 1'b1; B = 1'b1;
        tick(); tick();
        A = 1'b0; B = 1'b0; read_or_write = 1'b1;
        tick();
        checks++;
        if (dut.count !== 9'd3 || dout !== 1'b1 || C !== 1'b1) begin errors++; $display("FAIL async_setup: got count=%0d dout=%b C=%b want 3/1/1", dut.count, dout, C); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut.count !== 9'd0 || dout !== 1'b0 || C !== 1'b0) begin errors++; $display("FAIL async_clear: got count=%0d dout=%b C=%b want 0/0/0", dut.count, dout, C); end
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        A = 1'b0; B = 1'b0; en = 1'b0; read_or_write = 1'b0;
        test_reset();
        test_accumulate();
        test_enable_gating();
        test_empty_read();
        test_boundaries();
        test_overflow();
        test_back_to_back_readout();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
